// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller: bus register addresses, source count,
// FSM state type and the vector arithmetic.
package interrupt_controller_pkg;

  localparam logic [15:0] ADDR_IF     = 16'hFF0F;
  localparam logic [15:0] ADDR_IE     = 16'hFFFF;
  localparam int          NUM_INT_SRC = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKED = 2'd2
  } irq_state_e;

  function automatic logic [15:0] int_vector(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [15:0] idx);
    return base + stride * idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 is the most urgent request.
module int_priority_enc #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Isolate the lowest set bit.
  assign onehot_o = req_i & ~(req_i - N'(1));
  assign valid_o  = |req_i;

  // NOTE: idx_o gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE register pair on the memory bus plus request/acknowledge handshake that hands the
// highest-priority pending, enabled interrupt vector to the CPU.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC       = NUM_INT_SRC,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'd8
) (
  input  logic               I_CLOCK,
  input  logic               I_RESET_L,
  input  logic [15:0]        I_ADDR,
  inout  wire  [7:0]         IO_DATA,
  input  logic               I_RE_L,
  input  logic               I_WE_L,
  input  logic [NUM_SRC-1:0] I_INT_SRC,
  input  logic               I_IME,
  input  logic               I_INT_ACK,
  output logic               O_INT_REQ,
  output logic [15:0]        O_INT_VECTOR,
  output logic               O_INT_PENDING
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  irq_state_e         state_q, state_d;
  logic [15:0]        vector_q, vector_d;

  logic               if_wr, ie_wr, rd_if, rd_ie;
  logic [7:0]         rd_data;
  logic [NUM_SRC-1:0] pending, sel_onehot, ack_clr;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic [15:0]        sel_vector;

  assign if_wr = ~I_WE_L && (I_ADDR == ADDR_IF);
  assign ie_wr = ~I_WE_L && (I_ADDR == ADDR_IE);
  assign rd_if = ~I_RE_L && (I_ADDR == ADDR_IF);
  assign rd_ie = ~I_RE_L && (I_ADDR == ADDR_IE);

  assign rd_data = rd_ie ? ie_q : {{(8 - NUM_SRC){1'b1}}, if_q};
  assign IO_DATA = (rd_if || rd_ie) ? rd_data : 8'bz;

  assign pending = if_q & ie_q[NUM_SRC-1:0];

  int_priority_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_prio (
    .req_i    (pending),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .valid_o  (sel_valid)
  );

  assign sel_vector = int_vector(VECTOR_BASE, VECTOR_STRIDE, 16'(sel_idx));

  // A new source pulse is ORed in last so it survives a same-cycle write or ack clear.
  assign if_d = ((if_wr ? IO_DATA[NUM_SRC-1:0] : if_q) & ~ack_clr) | I_INT_SRC;
  assign ie_d = ie_wr ? IO_DATA : ie_q;

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    ack_clr  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) vector_d = sel_vector;
        if (I_IME && sel_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (I_INT_ACK && I_IME && sel_valid) begin
          ack_clr = sel_onehot;
          state_d = ST_ACKED;
        end else begin
          if (sel_valid) vector_d = sel_vector;
          if (!I_IME || !sel_valid) state_d = ST_IDLE;
        end
      end
      ST_ACKED: begin
        if (!I_INT_ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      if_q     <= '0;
      ie_q     <= '0;
      state_q  <= ST_IDLE;
      vector_q <= VECTOR_BASE;
    end else begin
      if_q     <= if_d;
      ie_q     <= ie_d;
      state_q  <= state_d;
      vector_q <= vector_d;
    end
  end

  assign O_INT_REQ     = (state_q == ST_REQ);
  assign O_INT_VECTOR  = vector_q;
  assign O_INT_PENDING = sel_valid;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: bus access to IF/IE, priority, handshake, reset.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  wire  [7:0]  io_data;
  logic [7:0]  drv_data;
  logic        drv_en;
  logic        re_l, we_l;
  logic [4:0]  int_src;
  logic        ime, ack;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_pending;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;

  assign io_data = drv_en ? drv_data : 8'bz;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .I_CLOCK       (clk),
    .I_RESET_L     (rst_n),
    .I_ADDR        (addr),
    .IO_DATA       (io_data),
    .I_RE_L        (re_l),
    .I_WE_L        (we_l),
    .I_INT_SRC     (int_src),
    .I_IME         (ime),
    .I_INT_ACK     (ack),
    .O_INT_REQ     (int_req),
    .O_INT_VECTOR  (int_vector),
    .O_INT_PENDING (int_pending)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr     = a;
    drv_data = d;
    drv_en   = 1'b1;
    we_l     = 1'b0;
    tick();
    we_l     = 1'b1;
    drv_en   = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    addr = a;
    re_l = 1'b0;
    #1;
    d    = io_data;
    re_l = 1'b1;
    #1;
    check(tag, 16'(d), 16'(exp));
  endtask

  task automatic pulse(input logic [4:0] s);
    int_src = s;
    tick();
    int_src = '0;
  endtask

  task automatic ack_cycle();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; addr = 16'h0000; drv_data = 8'h00; drv_en = 1'b0;
    re_l = 1'b1; we_l = 1'b1; int_src = '0; ime = 1'b0; ack = 1'b0;
    #23;
    check("rst_req", 16'(int_req), 16'h0);
    check("rst_vec", int_vector, 16'h0040);
    check("rst_pend", 16'(int_pending), 16'h0);
    check_rd("rst_if", A_IF, 8'hE0);
    check_rd("rst_ie", A_IE, 8'h00);
    rst_n = 1'b1;
    tick(); tick();

    // Single timer interrupt through one full handshake.
    bus_write(A_IE, 8'h04);
    ime = 1'b1;
    pulse(5'b00100);
    check_rd("t1_if_set", A_IF, 8'hE4);
    check("t1_req_n1", 16'(int_req), 16'h0);
    tick();
    check("t1_req", 16'(int_req), 16'h1);
    check("t1_vec", int_vector, 16'h0050);
    check("t1_pend", 16'(int_pending), 16'h1);
    ack = 1'b1;
    tick();
    check("t1_req_acked", 16'(int_req), 16'h0);
    check_rd("t1_if_clr", A_IF, 8'hE0);
    check("t1_vec_held", int_vector, 16'h0050);
    ack = 1'b0;
    tick(); tick();
    check("t1_idle", 16'(int_req), 16'h0);

    // Two sources at once: VBLANK first, then the timer.
    bus_write(A_IE, 8'h1F);
    check_rd("t2_ie", A_IE, 8'h1F);
    pulse(5'b00101);
    tick();
    check("t2_req0", 16'(int_req), 16'h1);
    check("t2_vec0", int_vector, 16'h0040);
    ack = 1'b1;
    tick();
    check_rd("t2_if_after", A_IF, 8'hE4);
    ack = 1'b0;
    tick();
    check("t2_idle_gap", 16'(int_req), 16'h0);
    tick();
    check("t2_req2", 16'(int_req), 16'h1);
    check("t2_vec2", int_vector, 16'h0050);
    ack_cycle();
    check_rd("t2_if_empty", A_IF, 8'hE0);

    // Pending without IME: wake-up only, then IME releases the request.
    ime = 1'b0;
    bus_write(A_IE, 8'h08);
    bus_write(A_IF, 8'h08);
    check("t3_pend", 16'(int_pending), 16'h1);
    check("t3_req_off", 16'(int_req), 16'h0);
    tick();
    check("t3_req_still_off", 16'(int_req), 16'h0);
    ime = 1'b1;
    tick();
    check("t3_req", 16'(int_req), 16'h1);
    check("t3_vec", int_vector, 16'h0058);
    ack_cycle();

    // A new pulse in the ack cycle keeps the bit set.
    bus_write(A_IE, 8'h04);
    pulse(5'b00100);
    tick();
    check("t4_req", 16'(int_req), 16'h1);
    ack = 1'b1;
    int_src = 5'b00100;
    tick();
    int_src = '0;
    check_rd("t4_if_kept", A_IF, 8'hE4);
    check("t4_req_acked", 16'(int_req), 16'h0);
    ack = 1'b0;
    tick();
    check("t4_idle", 16'(int_req), 16'h0);
    tick();
    check("t4_req_again", 16'(int_req), 16'h1);
    check("t4_vec", int_vector, 16'h0050);
    ack_cycle();

    // Preemption by VBLANK while the timer request waits for its ack.
    bus_write(A_IE, 8'h05);
    pulse(5'b00100);
    tick();
    check("t5_vec_timer", int_vector, 16'h0050);
    pulse(5'b00001);
    tick();
    check("t5_req", 16'(int_req), 16'h1);
    check("t5_vec_vblank", int_vector, 16'h0040);
    ack = 1'b1;
    tick();
    check_rd("t5_if_bit0_only", A_IF, 8'hE4);
    ack = 1'b0;
    tick(); tick();
    check("t5_req_timer", 16'(int_req), 16'h1);
    check("t5_vec_timer2", int_vector, 16'h0050);

    // Reset while ACKED with another bit pending.
    ack = 1'b1;
    tick();
    check("t6_acked", 16'(int_req), 16'h0);
    pulse(5'b00010);
    check_rd("t6_if_pre", A_IF, 8'hE2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", 16'(int_req), 16'h0);
    check("t6_rst_vec", int_vector, 16'h0040);
    check("t6_rst_pend", 16'(int_pending), 16'h0);
    check_rd("t6_rst_if", A_IF, 8'hE0);
    check_rd("t6_rst_ie", A_IE, 8'h00);
    ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t6_idle_req", 16'(int_req), 16'h0);
    check("t6_idle_vec", int_vector, 16'h0040);
    bus_write(A_IE, 8'h02);
    pulse(5'b00010);
    tick();
    check("t6_serve_req", 16'(int_req), 16'h1);
    check("t6_serve_vec", int_vector, 16'h0048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
